// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC control path: opcodes, FSM states,
// PC/ALU select codes and status-bit positions.
package sisc_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ALUR  = 4'h1;
    localparam logic [3:0] OP_ALUI  = 4'h2;
    localparam logic [3:0] OP_BRA   = 4'h4;
    localparam logic [3:0] OP_BRR   = 4'h5;
    localparam logic [3:0] OP_LOAD  = 4'h6;
    localparam logic [3:0] OP_STORE = 4'h7;
    localparam logic [3:0] OP_HLT   = 4'hF;

    typedef enum logic [2:0] {
        ST_START   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6
    } state_t;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_ABS = 2'b01;
    localparam logic [1:0] PC_REL = 2'b10;

    localparam logic [1:0] ALU_REG = 2'b00;
    localparam logic [1:0] ALU_IMM = 2'b01;

    localparam int STAT_C = 3;
    localparam int STAT_V = 2;
    localparam int STAT_N = 1;
    localparam int STAT_Z = 0;

    function automatic logic is_legal(input logic [3:0] op);
        return (op == OP_NOP) || (op == OP_ALUR) || (op == OP_ALUI) ||
               (op == OP_BRA) || (op == OP_BRR) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/sisc_br_cond.sv
// Branch condition: taken when the mask is empty (unconditional) or any
// masked status bit is set.
module br_cond
    import sisc_pkg::*;
(
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic       taken
);

    assign taken = (mm == 4'h0) || ((mm & stat) != 4'h0);

endmodule

// File: rtl/sisc_sequencer.sv
// Multicycle SISC sequencer: one state register with op/mask latched in
// DECODE, and datapath strobes decoded from state plus the latched op.
module sisc_sequencer
    import sisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir,
    input  logic [3:0]  stat,
    input  logic        imem_rdy,
    input  logic        dmem_rdy,
    output logic        imem_req,
    output logic        ir_load,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic [1:0]  alu_op,
    output logic        sr_enable,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        dmem_rd,
    output logic        dmem_wr,
    output logic        instr_done,
    output logic        illegal,
    output logic        halted
);

    state_t     state_q;
    logic [3:0] op_q;
    logic [3:0] mm_q;
    logic       taken;
    logic       unused_ir;

    assign unused_ir = ^ir[23:0];

    br_cond u_br_cond (
        .mm   (mm_q),
        .stat (stat),
        .taken(taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_START;
            op_q    <= 4'h0;
            mm_q    <= 4'h0;
        end else begin
            case (state_q)
                ST_START: state_q <= ST_FETCH;
                ST_FETCH: if (imem_rdy) state_q <= ST_DECODE;
                ST_DECODE: begin
                    op_q    <= ir[31:28];
                    mm_q    <= ir[27:24];
                    state_q <= (ir[31:28] == OP_HLT) ? ST_HALT : ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (op_q == OP_ALUR || op_q == OP_ALUI)
                        state_q <= ST_WB;
                    else if (op_q == OP_LOAD || op_q == OP_STORE)
                        state_q <= ST_MEM;
                    else
                        state_q <= ST_FETCH;
                end
                ST_MEM: if (dmem_rdy) state_q <= (op_q == OP_LOAD) ? ST_WB : ST_FETCH;
                ST_WB:   state_q <= ST_FETCH;
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_START;
            endcase
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = PC_INC;
        alu_op     = ALU_REG;
        sr_enable  = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = 1'b0;
        dmem_rd    = 1'b0;
        dmem_wr    = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_rdy;
                pc_write = imem_rdy;
            end
            ST_EXECUTE: begin
                case (op_q)
                    OP_ALUR: sr_enable = 1'b1;
                    OP_ALUI: begin
                        alu_op    = ALU_IMM;
                        sr_enable = 1'b1;
                    end
                    OP_LOAD, OP_STORE: alu_op = ALU_IMM;
                    OP_BRA, OP_BRR: begin
                        pc_write   = taken;
                        pc_sel     = taken ? ((op_q == OP_BRA) ? PC_ABS : PC_REL) : PC_INC;
                        instr_done = 1'b1;
                    end
                    default: begin
                        // Undefined opcodes retire as NOP but are flagged
                        instr_done = 1'b1;
                        illegal    = !is_legal(op_q);
                    end
                endcase
            end
            ST_MEM: begin
                dmem_rd    = (op_q == OP_LOAD);
                dmem_wr    = (op_q != OP_LOAD);
                instr_done = (op_q != OP_LOAD) && dmem_rdy;
            end
            ST_WB: begin
                rf_we      = 1'b1;
                wb_sel     = (op_q == OP_LOAD);
                instr_done = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sisc_sequencer.sv
// Bench for sisc_sequencer: each instruction is expanded into a per-cycle
// schedule of inputs and required outputs, then replayed and compared.
module tb_sisc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ir = 32'h0;
    logic [3:0]  stat = 4'h0;
    logic        imem_rdy = 1'b0;
    logic        dmem_rdy = 1'b0;
    logic        imem_req, ir_load, pc_write, sr_enable, rf_we, wb_sel;
    logic        dmem_rd, dmem_wr, instr_done, illegal, halted;
    logic [1:0]  pc_sel, alu_op;

    typedef struct packed {
        logic       imem_req;
        logic       ir_load;
        logic       pc_write;
        logic [1:0] pc_sel;
        logic [1:0] alu_op;
        logic       sr_enable;
        logic       rf_we;
        logic       wb_sel;
        logic       dmem_rd;
        logic       dmem_wr;
        logic       instr_done;
        logic       illegal;
        logic       halted;
    } out_t;

    typedef struct {
        logic        rst;
        logic [31:0] ir;
        logic [3:0]  stat;
        logic        imem_rdy;
        logic        dmem_rdy;
        out_t        exp;
        bit          inst;
        string       tag;
    } cyc_t;

    cyc_t sched[$];
    int   obs_lat[$];
    int   n_chk = 0;
    int   n_fail = 0;
    out_t got;

    assign got = {imem_req, ir_load, pc_write, pc_sel, alu_op, sr_enable,
                  rf_we, wb_sel, dmem_rd, dmem_wr, instr_done, illegal, halted};

    sisc_sequencer dut (
        .clk(clk), .rst(rst), .ir(ir), .stat(stat),
        .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
        .imem_req(imem_req), .ir_load(ir_load), .pc_write(pc_write),
        .pc_sel(pc_sel), .alu_op(alu_op), .sr_enable(sr_enable),
        .rf_we(rf_we), .wb_sel(wb_sel), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .instr_done(instr_done), .illegal(illegal), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic push(input logic r, input logic [31:0] i, input logic [3:0] s,
                        input logic ir_rdy, input logic dm_rdy, input out_t e,
                        input bit in_inst, input string t);
        cyc_t c;
        c.rst = r; c.ir = i; c.stat = s; c.imem_rdy = ir_rdy; c.dmem_rdy = dm_rdy;
        c.exp = e; c.inst = in_inst; c.tag = t;
        sched.push_back(c);
    endtask

    // Expand one instruction into its cycles from the opcode rules; if abort
    // is set, rst is raised in the first memory wait cycle.
    task automatic instr(input logic [31:0] i, input logic [3:0] s,
                         input int iw, input int dw, input bit abort);
        logic [3:0] op, mm;
        bit   tk, mem, wb;
        out_t e;
        op = i[31:28];
        mm = i[27:24];
        for (int k = 0; k < iw; k++) begin
            e = '0; e.imem_req = 1'b1;
            push(1'b0, i, s, 1'b0, 1'b1, e, 1'b1, "fetch_wait");
        end
        e = '0; e.imem_req = 1'b1; e.ir_load = 1'b1; e.pc_write = 1'b1;
        push(1'b0, i, s, 1'b1, 1'b0, e, 1'b1, "fetch");
        e = '0;
        push(1'b0, i, s, 1'b1, 1'b1, e, 1'b1, "decode");
        if (op == 4'hF) return;
        tk  = (mm == 4'h0) || ((mm & s) != 4'h0);
        mem = (op == 4'h6) || (op == 4'h7);
        wb  = (op == 4'h1) || (op == 4'h2) || (op == 4'h6);
        e = '0;
        if (op == 4'h1) e.sr_enable = 1'b1;
        if (op == 4'h2) begin e.sr_enable = 1'b1; e.alu_op = 2'b01; end
        if (mem) e.alu_op = 2'b01;
        if (op == 4'h4 && tk) begin e.pc_write = 1'b1; e.pc_sel = 2'b01; end
        if (op == 4'h5 && tk) begin e.pc_write = 1'b1; e.pc_sel = 2'b10; end
        if (!mem && !wb) e.instr_done = 1'b1;
        if (!(op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'hF}))
            e.illegal = 1'b1;
        push(1'b0, i, s, 1'b1, 1'b1, e, 1'b1, "execute");
        if (mem) begin
            e = '0; e.dmem_rd = (op == 4'h6); e.dmem_wr = (op == 4'h7);
            if (abort) begin
                push(1'b1, i, s, 1'b1, 1'b0, e, 1'b1, "mem_abort");
                e = '0;
                push(1'b0, i, s, 1'b0, 1'b0, e, 1'b0, "start_after_abort");
                return;
            end
            for (int k = 0; k < dw; k++)
                push(1'b0, i, s, 1'b1, 1'b0, e, 1'b1, "mem_wait");
            e.instr_done = (op == 4'h7);
            push(1'b0, i, s, 1'b0, 1'b1, e, 1'b1, "mem_done");
        end
        if (wb) begin
            e = '0; e.rf_we = 1'b1; e.wb_sel = (op == 4'h6); e.instr_done = 1'b1;
            push(1'b0, i, s, 1'b1, 1'b1, e, 1'b1, "writeback");
        end
    endtask

    initial begin
        out_t e;
        int   lat;
        int   want_lat[$];

        e = '0;
        push(1'b1, 32'h0, 4'h0, 1'b1, 1'b1, e, 1'b0, "reset");
        push(1'b1, 32'h0, 4'h0, 1'b1, 1'b1, e, 1'b0, "reset");
        push(1'b0, 32'h0, 4'h0, 1'b1, 1'b1, e, 1'b0, "start");
        instr(32'h1000_0000, 4'h0, 0, 0, 0);
        instr(32'h2300_1234, 4'h0, 0, 0, 0);
        instr(32'h4100_0000, 4'h1, 0, 0, 0);
        instr(32'h4100_0000, 4'h0, 0, 0, 0);
        instr(32'h5000_0000, 4'h0, 0, 0, 0);
        instr(32'h5600_0010, 4'h2, 0, 0, 0);
        instr(32'h6000_0000, 4'h0, 0, 3, 0);
        instr(32'h0000_0000, 4'h0, 2, 0, 0);
        instr(32'h7000_0000, 4'h0, 0, 0, 0);
        instr(32'h7000_0000, 4'h0, 0, 1, 0);
        instr(32'h9000_0000, 4'h0, 0, 0, 0);
        instr(32'h7000_0000, 4'h0, 0, 2, 1);
        instr(32'hF000_0000, 4'h0, 0, 0, 0);
        e = '0; e.halted = 1'b1;
        for (int k = 0; k < 3; k++)
            push(1'b0, 32'hF000_0000, 4'h0, 1'b1, 1'b1, e, 1'b1, "halted");
        push(1'b1, 32'hF000_0000, 4'h0, 1'b1, 1'b1, e, 1'b1, "halted_rst");
        e = '0;
        push(1'b0, 32'h0, 4'h0, 1'b1, 1'b1, e, 1'b0, "start_after_halt");
        instr(32'h0000_0000, 4'h0, 0, 0, 0);

        lat = 0;
        for (int idx = 0; idx < sched.size(); idx++) begin
            @(negedge clk);
            rst = sched[idx].rst; ir = sched[idx].ir; stat = sched[idx].stat;
            imem_rdy = sched[idx].imem_rdy; dmem_rdy = sched[idx].dmem_rdy;
            #1;
            n_chk++;
            if (got !== sched[idx].exp) begin
                n_fail++;
                $display("FAIL cyc%0d %s outputs got=%h exp=%h", idx, sched[idx].tag,
                         got, sched[idx].exp);
            end
            if (sched[idx].inst) lat++;
            if (got.instr_done === 1'b1) begin
                obs_lat.push_back(lat);
                lat = 0;
            end
            if (sched[idx].rst) lat = 0;
        end

        // Hand-derived latencies: ALU 4, branch/NOP 3, LOAD+3 waits 8,
        // NOP+2 fetch waits 5, STORE 4, STORE+1 wait 5, illegal 3, NOP 3.
        want_lat = '{4, 4, 3, 3, 3, 3, 8, 5, 4, 5, 3, 3};
        n_chk++;
        if (obs_lat.size() != want_lat.size()) begin
            n_fail++;
            $display("FAIL retire_count got=%0d exp=%0d", obs_lat.size(), want_lat.size());
        end else begin
            for (int k = 0; k < want_lat.size(); k++) begin
                n_chk++;
                if (obs_lat[k] != want_lat[k]) begin
                    n_fail++;
                    $display("FAIL latency[%0d] got=%0d exp=%0d", k, obs_lat[k], want_lat[k]);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sisc_sequencer.md
# sisc_sequencer

Multicycle instruction sequencer for the SISC core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the load and write-enable strobes for the PC, IR, ALU, status register, register file and data memory. It handshakes with instruction and data memory so that waits of any length stall it cleanly. It sits between the IR/status register and the datapath, replacing ad-hoc per-opcode strobing with one state machine.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ir  in  32  current instruction; opcode = ir[31:28], mm = ir[27:24].
- stat  in  4  status register output; bit 3 = C, 2 = V, 1 = N, 0 = Z.
- imem_rdy  in  1  instruction memory has valid data this cycle.
- dmem_rdy  in  1  data memory access completes this cycle.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  IR register load strobe.
- pc_write  out  1  PC register load strobe.
- pc_sel  out  2  PC source: 00 = PC+1, 01 = absolute (imm), 10 = PC+1+imm.
- alu_op  out  2  ALU function select.
- sr_enable  out  1  status register load.
- rf_we  out  1  register file write enable.
- wb_sel  out  1  writeback source: 0 = ALU, 1 = data memory.
- dmem_rd  out  1  data read request.
- dmem_wr  out  1  data write request.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  one-cycle pulse in EXECUTE for an undefined opcode.
- halted  out  1  high while in HALT.

## Operation
- Opcodes:
  - 0x0 NOP
  - 0x1 ALU reg-reg
  - 0x2 ALU reg-imm
  - 0x4 BRA (absolute, conditional)
  - 0x5 BRR (relative, conditional)
  - 0x6 LOAD
  - 0x7 STORE
  - 0xF HLT
  - All other opcodes execute as NOP and pulse `illegal`.
- Branch taken when mm == 0, or when (mm & stat) != 0.
- States (3-bit encoding): START=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6.
- Outputs are decoded combinationally from the current state and the latched op_q/mm_q. Every output not listed for a state is 0.
- START: all outputs 0. Next state is FETCH.
- FETCH:
  - imem_req = 1.
  - When imem_rdy = 1: ir_load = 1, pc_write = 1, pc_sel = 00, next state DECODE.
  - Otherwise remain in FETCH.
- DECODE:
  - Latch op_q <= ir[31:28] and mm_q <= ir[27:24].
  - HLT goes to HALT; all other opcodes go to EXECUTE.
- EXECUTE:
  - ALU reg: alu_op = 00, sr_enable = 1, next state WB.
  - ALU imm: alu_op = 01, sr_enable = 1, next state WB.
  - LOAD/STORE: alu_op = 01 (address = rs + imm), sr_enable = 0, next state MEM.
  - BRA/BRR taken: pc_write = 1, pc_sel = 01 or 10 respectively.
  - BRA/BRR, NOP, illegal: instr_done = 1, next state FETCH.
- MEM:
  - LOAD holds dmem_rd = 1 and STORE holds dmem_wr = 1 until dmem_rdy = 1.
  - On completion, STORE pulses instr_done and goes to FETCH; LOAD goes to WB.
- WB: rf_we = 1, wb_sel = 1 for LOAD and 0 for ALU ops, instr_done = 1, next state FETCH.
- HALT: halted = 1, all other outputs 0. Only rst exits.

## Timing
- rst sampled high at an edge puts the state in START. The first FETCH is one cycle after rst is released. op_q and mm_q reset to 0.
- rst mid-instruction (including during a memory wait) aborts it. No further strobes are issued, and any in-flight dmem_rd/dmem_wr drops at that edge.
- Latency with zero-wait memories:
  - ALU: 4 cycles (F, D, E, W).
  - Branch and NOP: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- stat is sampled in EXECUTE. The previous instruction's sr_enable edge has already updated it, so no forwarding is needed.
- imem_rdy outside FETCH and dmem_rdy outside MEM are ignored.
- pc_write in FETCH and pc_write for a taken branch never coincide. Both are single-cycle.

## Structure
- Package sisc_pkg holds:
  - opcode constants
  - state encodings
  - pc_sel codes
  - alu_op codes
  - stat bit indices
- One combinational sub-module, br_cond (inputs mm, stat; output taken), which is reusable by a later pipelined control unit.
- The rest is a single state register plus output decode in sisc_sequencer.

## Test plan
- ALU reg-reg (ir = 0x1000_0000), imem_rdy tied 1 -> states 1, 2, 3, 5, 1. sr_enable high in cycle 3, rf_we high with wb_sel = 0 in cycle 4. instr_done pulses once.
- BRA with mm = 0x1, stat = 0x1 -> pc_write = 1, pc_sel = 01 in EXECUTE. Same test with stat = 0x0 -> pc_write stays 0 in EXECUTE.
- LOAD with dmem_rdy low for 3 cycles -> dmem_rd held 4 cycles, then WB with rf_we = 1, wb_sel = 1. Total 8 cycles.
- imem_rdy low for 2 cycles in FETCH -> imem_req stays high, with no ir_load or pc_write until imem_rdy rises.
- HLT (0xF…) -> halted = 1 from the cycle after DECODE. Further imem_rdy is ignored. rst returns the FSM to START with all outputs 0.
- Opcode 0x9 -> illegal pulses in EXECUTE, instr_done pulses, and the FSM returns to FETCH. Asserting rst during a STORE memory wait -> dmem_wr drops at the next edge and the state goes to START.
